// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate: AHB-Lite word SRAM responder with configurable wait states and two-cycle ERROR.
module ahb_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  input  logic                  Hsel,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [1:0]            Htrans,
  input  logic                  Hwrite,
  input  logic [2:0]            Hsize,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic                  Hready,
  output logic                  Hreadyout,
  output logic                  Hresp,
  output logic [DATA_WIDTH-1:0] Hrdata
);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state_q, state_d, acc_state;
  logic [3:0] cnt_q, cnt_d, be;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0] lo_q, lo_d;
  logic [2:0] size_q, size_d;
  logic write_q, write_d, hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic open, accept, illegal, we, unused_bits;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  assign unused_bits = ^{Haddr[ADDR_WIDTH-1:IW+2], Htrans[0]};
  always_comb begin
    open        = state_q inside {S_IDLE, S_DATA, S_ERR2};
    accept      = open & Hsel & Hready & Htrans[1];
    illegal     = (Hsize > 3'd2) | (Hsize == 3'd1 & Haddr[0]) | (Hsize == 3'd2 & |Haddr[1:0]);
    acc_state   = !accept ? S_IDLE : illegal ? S_ERR1 : WAIT_STATES == 0 ? S_DATA : S_WAIT;
    state_d     = state_q == S_WAIT ? (cnt_q == 4'd1 ? S_DATA : S_WAIT) :
                  state_q == S_ERR1 ? S_ERR2 : acc_state;
    cnt_d       = state_q == S_WAIT ? cnt_q - 4'd1 : (accept & !illegal) ? 4'(WAIT_STATES) : cnt_q;
    idx_d       = accept ? Haddr[IW+1:2] : idx_q;
    lo_d        = accept ? Haddr[1:0] : lo_q;
    size_d      = accept ? Hsize : size_q;
    write_d     = accept ? Hwrite : write_q;
    hreadyout_d = !(state_d inside {S_WAIT, S_ERR1});
    hresp_d     = state_d inside {S_ERR1, S_ERR2};
    be          = size_q == 3'd0 ? 4'b0001 << lo_q : size_q == 3'd1 ? (lo_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    we          = state_q == S_DATA & write_q & !Hreset;
  end
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lo_q        <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      size_q      <= size_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end
  always_ff @(posedge Hclk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[idx_q][8*i +: 8] <= Hwdata[8*i +: 8];
  end
  assign Hreadyout = hreadyout_q;
  assign Hresp     = hresp_q;
  assign Hrdata    = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;
endmodule
